// File: rtl/vai_rd_sched.sv
// Round-robin read scheduler for sub-AFUs with per-AFU outstanding-read credits.
// Define VAI_RD_SCHED_OFFSET_EN to add the per-AFU offset_array value to upstream addresses.
module vai_rd_sched #(
    parameter int NUM_SUB_AFUS    = 8,
    parameter int MAX_OUTSTANDING = 64,
    localparam int VMID_WIDTH     = $clog2(NUM_SUB_AFUS) + 1,
    localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_SUB_AFUS-1:0]            afu_rd_valid,
    input  logic [NUM_SUB_AFUS-1:0][41:0]      afu_rd_addr,
    input  logic [NUM_SUB_AFUS-1:0][15:0]      afu_rd_mdata,
    output logic [NUM_SUB_AFUS-1:0]            afu_rd_grant,
    input  logic [NUM_SUB_AFUS-1:0][63:0]      offset_array,
    input  logic                               up_c0_almfull,
    output logic                               up_rd_valid,
    output logic [41:0]                        up_rd_addr,
    output logic [15:0]                        up_rd_mdata,
    input  logic                               rsp_valid,
    input  logic [VMID_WIDTH-1:0]              rsp_vmid,
    output logic                               credit_err
);

    localparam int PTR_W = (NUM_SUB_AFUS > 1) ? $clog2(NUM_SUB_AFUS) : 1;
    localparam int LOW_W = 16 - VMID_WIDTH;

    logic [NUM_SUB_AFUS-1:0] eligible;
    logic                    grant_vld;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]    cnt_q [NUM_SUB_AFUS];
    logic [CNT_WIDTH-1:0]    cnt_d [NUM_SUB_AFUS];
    logic                    credit_err_q, err_d;
    logic                    up_rd_valid_q;
    logic [41:0]             up_rd_addr_q, up_rd_addr_d;
    logic [15:0]             up_rd_mdata_q, up_rd_mdata_d;

    // Upper offset bits and the vmid-overlaid mdata bits never reach the outputs.
    logic unused_inputs;
    assign unused_inputs = ^{offset_array, afu_rd_mdata};

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            eligible[i] = reset_n && afu_rd_valid[i] && !up_c0_almfull &&
                          (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        int idx;
        idx          = 0;
        grant_vld    = 1'b0;
        grant_idx    = '0;
        afu_rd_grant = '0;
        for (int k = 0; k < NUM_SUB_AFUS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SUB_AFUS) idx = idx - NUM_SUB_AFUS;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
        if (grant_vld) afu_rd_grant[grant_idx] = 1'b1;
    end

    always_comb begin
        up_rd_addr_d  = '0;
        up_rd_mdata_d = '0;
        rr_ptr_d      = rr_ptr_q;
        if (grant_vld) begin
`ifdef VAI_RD_SCHED_OFFSET_EN
            up_rd_addr_d = afu_rd_addr[grant_idx] + offset_array[grant_idx][41:0];
`else
            up_rd_addr_d = afu_rd_addr[grant_idx];
`endif
            up_rd_mdata_d = {VMID_WIDTH'(grant_idx), afu_rd_mdata[grant_idx][LOW_W-1:0]};
            rr_ptr_d      = (int'(grant_idx) == NUM_SUB_AFUS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // A grant and a response to the same AFU cancel; only a lone response can underflow.
    always_comb begin
        logic inc, dec;
        inc   = 1'b0;
        dec   = 1'b0;
        err_d = 1'b0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            inc      = grant_vld && (grant_idx == PTR_W'(i));
            dec      = rsp_valid && (rsp_vmid == VMID_WIDTH'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments; the small counter array is reset too,
    // since credits of a discarded request must not survive reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            up_rd_valid_q <= 1'b0;
            up_rd_addr_q  <= '0;
            up_rd_mdata_q <= '0;
            credit_err_q  <= 1'b0;
            rr_ptr_q      <= '0;
            for (int i = 0; i < NUM_SUB_AFUS; i++) cnt_q[i] <= '0;
        end else begin
            up_rd_valid_q <= grant_vld;
            up_rd_addr_q  <= up_rd_addr_d;
            up_rd_mdata_q <= up_rd_mdata_d;
            credit_err_q  <= credit_err_q | err_d;
            rr_ptr_q      <= rr_ptr_d;
            for (int i = 0; i < NUM_SUB_AFUS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign up_rd_valid = up_rd_valid_q;
    assign up_rd_addr  = up_rd_addr_q;
    assign up_rd_mdata = up_rd_mdata_q;
    assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_vai_rd_sched.sv
// Self-checking bench for vai_rd_sched: directed scenarios plus randomized traffic
// compared against a credit/round-robin reference model.
module tb_vai_rd_sched;

    localparam int N   = 8;
    localparam int MAX = 4;
    localparam int VW  = $clog2(N) + 1;
    localparam int LW  = 16 - VW;

    logic                clk;
    logic                reset_n;
    logic [N-1:0]        afu_rd_valid;
    logic [N-1:0][41:0]  afu_rd_addr;
    logic [N-1:0][15:0]  afu_rd_mdata;
    logic [N-1:0]        afu_rd_grant;
    logic [N-1:0][63:0]  offset_array;
    logic                up_c0_almfull;
    logic                up_rd_valid;
    logic [41:0]         up_rd_addr;
    logic [15:0]         up_rd_mdata;
    logic                rsp_valid;
    logic [VW-1:0]       rsp_vmid;
    logic                credit_err;

    vai_rd_sched #(.NUM_SUB_AFUS(N), .MAX_OUTSTANDING(MAX)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .afu_rd_valid (afu_rd_valid),
        .afu_rd_addr  (afu_rd_addr),
        .afu_rd_mdata (afu_rd_mdata),
        .afu_rd_grant (afu_rd_grant),
        .offset_array (offset_array),
        .up_c0_almfull(up_c0_almfull),
        .up_rd_valid  (up_rd_valid),
        .up_rd_addr   (up_rd_addr),
        .up_rd_mdata  (up_rd_mdata),
        .rsp_valid    (rsp_valid),
        .rsp_vmid     (rsp_vmid),
        .credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          m_cnt [N];
    int          m_rr;
    logic        m_err;
    logic        m_valid;
    logic [41:0] m_addr;
    logic [15:0] m_mdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [N-1:0] obs_grant;

    function automatic int model_pick();
        if (!reset_n || up_c0_almfull) return -1;
        for (int k = 0; k < N; k++) begin
            int a;
            a = (m_rr + k) % N;
            if (afu_rd_valid[a] && m_cnt[a] < MAX) return a;
        end
        return -1;
    endfunction

    function automatic logic [41:0] model_addr(input int a);
        logic [42:0] s;
`ifdef VAI_RD_SCHED_OFFSET_EN
        s = {1'b0, afu_rd_addr[a]} + {1'b0, offset_array[a][41:0]};
`else
        s = {1'b0, afu_rd_addr[a]};
`endif
        return s[41:0];
    endfunction

    task automatic model_edge(input int g);
        if (!reset_n) begin
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
            m_rr = 0; m_err = 1'b0; m_valid = 1'b0; m_addr = '0; m_mdata = '0;
            return;
        end
        m_valid = (g >= 0);
        m_addr  = '0;
        m_mdata = '0;
        if (g >= 0) begin
            m_addr  = model_addr(g);
            m_mdata = {VW'(g), afu_rd_mdata[g][LW-1:0]};
            m_cnt[g]++;
            m_rr = (g + 1) % N;
        end
        if (rsp_valid && int'(rsp_vmid) < N) begin
            int v;
            v = int'(rsp_vmid);
            if (m_cnt[v] == 0) m_err = 1'b1;
            else               m_cnt[v]--;
        end
    endtask

    // One clock: check the combinational grant, advance, check registered outputs.
    task automatic step(input string tag);
        int g;
        logic [N-1:0] eg;
        g  = model_pick();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        #1;
        obs_grant = afu_rd_grant;
        n_checks++;
        if (afu_rd_grant !== eg) begin
            n_fail++;
            $display("FAIL %s grant: actual %b expected %b", tag, afu_rd_grant, eg);
        end
        @(posedge clk);
        model_edge(g);
        #1;
        n_checks++;
        if ({up_rd_valid, up_rd_addr, up_rd_mdata, credit_err} !== {m_valid, m_addr, m_mdata, m_err}) begin
            n_fail++;
            $display("FAIL %s outputs: actual v=%b a=%h m=%h e=%b expected v=%b a=%h m=%h e=%b",
                     tag, up_rd_valid, up_rd_addr, up_rd_mdata, credit_err,
                     m_valid, m_addr, m_mdata, m_err);
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset_n = 1'b1; afu_rd_valid = '0; up_c0_almfull = 1'b0;
        rsp_valid = 1'b0; rsp_vmid = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        step("reset_seq");
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        for (int i = 0; i < N; i++) begin
            afu_rd_addr[i]  = 42'({$urandom(), $urandom()});
            afu_rd_mdata[i] = 16'($urandom());
            offset_array[i] = {$urandom(), $urandom()};
        end
        afu_rd_valid = '1;
        reset_n = 1'b0;
        step("reset");
        step("reset");
        n_checks++;
        if ({up_rd_valid, up_rd_addr, up_rd_mdata, credit_err, obs_grant} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: actual v=%b a=%h m=%h e=%b g=%b expected all zero",
                     up_rd_valid, up_rd_addr, up_rd_mdata, credit_err, obs_grant);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_rr_alternate();
        int exp_seq [4];
        exp_seq = '{2, 5, 2, 5};
        do_reset();
        afu_rd_valid = 8'b0010_0100;
        for (int j = 0; j < 4; j++) begin
            step("rr");
            n_checks++;
            if (obs_grant !== (8'b1 << exp_seq[j]) || up_rd_mdata[15:12] !== 4'(exp_seq[j])) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: actual grant=%b vmid=%0d expected afu %0d",
                         j, obs_grant, up_rd_mdata[15:12], exp_seq[j]);
            end
        end
        afu_rd_valid = '0;
    endtask

    task automatic test_offset();
        logic [41:0] exp_addr;
`ifdef VAI_RD_SCHED_OFFSET_EN
        exp_addr = 42'h000;
`else
        exp_addr = 42'h100;
`endif
        do_reset();
        afu_rd_addr[3]  = 42'h100;
        offset_array[3] = 64'h3FF_FFFF_FF00;
        afu_rd_valid    = 8'b0000_1000;
        step("offset");
        n_checks++;
        if (up_rd_addr !== exp_addr || up_rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL offset_addr: actual %h (v=%b) expected %h", up_rd_addr, up_rd_valid, exp_addr);
        end
        afu_rd_valid = '0;
    endtask

    task automatic test_max_outstanding();
        int n;
        do_reset();
        afu_rd_valid = 8'b0000_0001;
        n = 0;
        for (int j = 0; j < 8; j++) begin
            step("max_out");
            if (obs_grant[0]) n++;
        end
        n_checks++;
        if (n !== MAX) begin
            n_fail++;
            $display("FAIL max_out_grants: actual %0d expected %0d", n, MAX);
        end
        rsp_valid = 1'b1; rsp_vmid = '0;
        n = 0;
        step("max_out_rsp");
        if (obs_grant[0]) n++;
        rsp_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step("max_out_after");
            if (obs_grant[0]) n++;
        end
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL max_out_refill: actual %0d expected 1", n);
        end
        afu_rd_valid = '0;
    endtask

    task automatic test_almfull();
        do_reset();
        afu_rd_valid = 8'b0000_0010;
        step("almfull_grant");
        up_c0_almfull = 1'b1;
        n_checks++;
        if (up_rd_valid !== 1'b1 || up_rd_mdata[15:12] !== 4'd1) begin
            n_fail++;
            $display("FAIL almfull_issue: actual v=%b vmid=%0d expected v=1 vmid=1",
                     up_rd_valid, up_rd_mdata[15:12]);
        end
        for (int j = 0; j < 4; j++) begin
            step("almfull_block");
            n_checks++;
            if (obs_grant !== '0) begin
                n_fail++;
                $display("FAIL almfull_no_grant: actual %b expected 0", obs_grant);
            end
        end
        up_c0_almfull = 1'b0;
        afu_rd_valid  = '0;
    endtask

    task automatic test_credit_err();
        do_reset();
        rsp_valid = 1'b1; rsp_vmid = 4'd15;
        step("cerr_ignore");
        n_checks++;
        if (credit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cerr_out_of_range: actual %b expected 0", credit_err);
        end
        rsp_vmid = 4'd1;
        step("cerr_set");
        rsp_valid = 1'b0;
        for (int j = 0; j < 3; j++) step("cerr_hold");
        rsp_valid = 1'b1; rsp_vmid = 4'd15;
        step("cerr_hold");
        rsp_valid = 1'b0;
        n_checks++;
        if (credit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cerr_sticky: actual %b expected 1", credit_err);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        afu_rd_valid = 8'b0001_0000;
        step("b2b");
        step("b2b");
        rsp_valid = 1'b1; rsp_vmid = 4'd4;
        step("b2b_same_cycle");
        n_checks++;
        if (obs_grant !== 8'b0001_0000) begin
            n_fail++;
            $display("FAIL same_cycle_grant: actual %b expected 00010000", obs_grant);
        end
        rsp_valid = 1'b0;
        n = 0;
        for (int j = 0; j < 6; j++) begin
            step("b2b_fill");
            if (obs_grant[4]) n++;
        end
        n_checks++;
        if (n !== 2) begin
            n_fail++;
            $display("FAIL same_cycle_credit: actual %0d further grants expected 2", n);
        end
        rsp_valid = 1'b1; rsp_vmid = 4'd4;
        step("b2b_free");
        rsp_valid = 1'b0;
        step("b2b_regrant");
        reset_n = 1'b0;
        step("b2b_midreset");
        n_checks++;
        if ({up_rd_valid, up_rd_addr, up_rd_mdata, credit_err, obs_grant} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: actual v=%b a=%h m=%h e=%b g=%b expected all zero",
                     up_rd_valid, up_rd_addr, up_rd_mdata, credit_err, obs_grant);
        end
        reset_n = 1'b1;
        n = 0;
        for (int j = 0; j < 8; j++) begin
            step("b2b_after_reset");
            if (obs_grant[4]) n++;
        end
        n_checks++;
        if (n !== MAX) begin
            n_fail++;
            $display("FAIL credits_cleared: actual %0d grants expected %0d", n, MAX);
        end
        afu_rd_valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int r;
            reset_n       = ($urandom_range(0, 99) != 0);
            afu_rd_valid  = N'($urandom());
            up_c0_almfull = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                afu_rd_addr[i]  = 42'({$urandom(), $urandom()});
                afu_rd_mdata[i] = 16'($urandom());
                offset_array[i] = {$urandom(), $urandom()};
            end
            rsp_valid = 1'b0;
            rsp_vmid  = '0;
            r = int'($urandom_range(0, 3));
            if (r == 1) begin
                rsp_valid = 1'b1;
                rsp_vmid  = VW'($urandom_range(N, (1 << VW) - 1));
            end else if (r >= 2) begin
                int start;
                start = int'($urandom_range(0, N - 1));
                for (int k = 0; k < N; k++) begin
                    if (!rsp_valid && m_cnt[(start + k) % N] > 0) begin
                        rsp_valid = 1'b1;
                        rsp_vmid  = VW'((start + k) % N);
                    end
                end
            end
            step("random");
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        set_idle();
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        m_rr = 0; m_err = 1'b0; m_valid = 1'b0; m_addr = '0; m_mdata = '0;
        afu_rd_addr = '0; afu_rd_mdata = '0; offset_array = '0;
        reset_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_rr_alternate();
        test_offset();
        test_max_outstanding();
        test_almfull();
        test_credit_err();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
